executor_merge: RTL and testbench
=================================

EXECUTOR_MERGE -- requirements
Module: executor_merge

Interface
REQ-001 Parameter width_p, default 16: matrix row width in columns.
REQ-002 Parameter height_p, default 32: matrix row count.
REQ-003 Parameter debug_p, default 0: nonzero enables per-cycle $display of state, row counter and flags.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset_i, input, 1: synchronous, active-high reset.
REQ-007 Port v_i, input, 1: merge request, valid with piece_i/x_i/y_i.
REQ-008 Port ready_o, output, 1: high only in eIDLE.
REQ-009 Port piece_i, input, 16: 4x4 piece bitmap; row r = piece_i[4r+3:4r], bit c = column c.
REQ-010 Port x_i, input, $clog2(width_p): matrix column of the piece's column 0.
REQ-011 Port y_i, input, $clog2(height_p): matrix row of the piece's row 0.
REQ-012 Port mm_read_addr_o, output, $clog2(height_p): matrix read address; read data is same-cycle combinational.
REQ-013 Port mm_read_data_i, input, width_p: matrix row at mm_read_addr_o.
REQ-014 Ports mm_write_addr_o ($clog2(height_p)), mm_write_data_o (width_p), mm_write_v_o (1), outputs: matrix write port.
REQ-015 Port done_o, output, 1: one-cycle pulse at end of merge; drives the line-clear checker's v_i.
REQ-016 Ports collision_o and clip_o, outputs, 1 each: sticky per-operation flags, valid while done_o is high and held until the next accept.

Function
REQ-017 FSM states: eIDLE, eMerge, eDone.
REQ-018 eIDLE with v_i=1 SHALL latch piece_i, x_i and y_i, clear row counter row_r to 0, clear both flags, and go to eMerge.
REQ-019 v_i outside eIDLE SHALL be ignored.
REQ-020 eMerge SHALL last exactly 4 cycles, one per row_r = 0..3, then go to eDone; eDone SHALL last 1 cycle, then go to eIDLE.
REQ-021 Latency: accept at cycle T; merge cycles T+1..T+4; done_o at T+5; ready_o high at T+6.
REQ-022 In eMerge, mm_read_addr_o = mm_write_addr_o = y_r + row_r, computed one bit wider than the address to detect overflow.
REQ-023 Row mask = zero-extended piece row << x_r, truncated to width_p; bits shifted past column width_p-1 SHALL set clip_o.
REQ-024 mm_write_data_o = mm_read_data_i | mask.
REQ-025 mm_write_v_o SHALL be 1 only in eMerge, when y_r + row_r <= height_p-1 and mask is nonzero.
REQ-026 A nonzero piece row whose target row exceeds height_p-1 SHALL set clip_o and SHALL NOT be written.
REQ-027 Outside eMerge, mm_write_v_o = 0 and mm_read_addr_o = 0.

Reset
REQ-028 On reset: state eIDLE, row_r 0, flags 0, done_o 0, mm_write_v_o 0, ready_o 1 in the following cycle.
REQ-029 Reset during eMerge SHALL abort the operation with no further writes; rows already written are not restored.

Configuration
REQ-030 With macro EXECUTOR_MERGE_COLLISION_EN defined, collision_o SHALL be set when (mm_read_data_i & mask) != 0 in any written merge cycle; the write still occurs.
REQ-031 With the macro undefined, collision_o SHALL be tied to 0 and no overlap logic SHALL exist.

Structure
REQ-032 Shared package tetris_pkg SHALL hold the merge_state_e enum (eIDLE, eMerge, eDone) and the constants piece_rows_lp = 4 and piece_cols_lp = 4.
REQ-033 Sub-module piece_row_shifter: combinational shift of a 4-bit row by x into width_p bits plus a clip bit; one instance.

Verification
REQ-034 Empty matrix; piece 16'h0033, x=3, y=10, v_i=1 -> rows 10 and 11 written 16'h0018; rows 12 and 13 not written; done_o at T+5; flags 0.
REQ-035 Piece 16'h000F, x=14 -> row y written 16'hC000; clip_o=1.
REQ-036 Piece 16'hF000, y=29 -> no write (target row 32); clip_o=1; done_o still at T+5.
REQ-037 Macro defined; row 5 = 16'h0010; piece 16'h0001, x=4, y=5 -> row 5 written 16'h0010; collision_o=1. Macro undefined: same stimulus -> collision_o=0.
REQ-038 reset_i at T+2 -> only the row_r=0 write occurs; next cycle ready_o=1, done_o never pulses.
REQ-039 v_i held high through a whole operation -> exactly one accept; second accept at T+6.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the playfield merge datapath.
package tetris_pkg;

  localparam int piece_rows_lp = 4;
  localparam int piece_cols_lp = 4;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eMerge = 2'd1,
    eDone  = 2'd2
  } merge_state_e;

  // Observation bundle for checkers and debug visibility.
  typedef struct packed {
    merge_state_e state;
    logic [1:0]   row;
    logic         collision;
    logic         clip;
  } merge_debug_s;

endpackage

// File: rtl/piece_row_shifter.sv
// Places one 4-bit piece row at column x of a width_p-wide matrix row;
// clip_o flags any piece bit pushed beyond the last column.
module piece_row_shifter
  import tetris_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic [piece_cols_lp-1:0]   row_i,
  input  logic [$clog2(width_p)-1:0] x_i,
  output logic [width_p-1:0]         mask_o,
  output logic                       clip_o
);

  // Wide enough that no bit is lost for any representable x.
  localparam int ext_w_lp = (1 << $clog2(width_p)) + piece_cols_lp;

  logic [ext_w_lp-1:0] w_ext;

  assign w_ext  = ext_w_lp'(row_i) << x_i;
  assign mask_o = w_ext[width_p-1:0];
  assign clip_o = |w_ext[ext_w_lp-1:width_p];

endmodule

// File: rtl/executor_merge.sv
// ORs a latched 4x4 piece into the matrix, one row per cycle, flagging clipping.
// Optional overlap detection is enabled with macro EXECUTOR_MERGE_COLLISION_EN.
module executor_merge
  import tetris_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32,
  parameter int debug_p  = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  // v_i/ready_o: a request transfers on a rising edge where both are high;
  // v_i in any other cycle is ignored and nothing is held for later.
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [15:0]                 piece_i,
  input  logic [$clog2(width_p)-1:0]  x_i,
  input  logic [$clog2(height_p)-1:0] y_i,
  output logic [$clog2(height_p)-1:0] mm_read_addr_o,
  input  logic [width_p-1:0]          mm_read_data_i,
  output logic [$clog2(height_p)-1:0] mm_write_addr_o,
  output logic [width_p-1:0]          mm_write_data_o,
  output logic                        mm_write_v_o,
  output logic                        done_o,
  output logic                        collision_o,
  output logic                        clip_o,
  output merge_debug_s                debug_o
);

  localparam int aw_lp = $clog2(height_p);
  localparam int xw_lp = $clog2(width_p);

  merge_state_e              r_state;
  logic [1:0]                r_row;
  logic [15:0]               r_piece;
  logic [xw_lp-1:0]          r_x;
  logic [aw_lp-1:0]          r_y;
  logic                      r_clip;

  logic                      w_merge;
  logic [aw_lp:0]            w_sum;
  logic                      w_in_range;
  logic [piece_cols_lp-1:0]  w_row;
  logic [width_p-1:0]        w_mask;
  logic                      w_shift_clip;
  logic                      w_clip_now;
  logic                      w_write;

  assign w_merge    = (r_state == eMerge);
  assign w_sum      = {1'b0, r_y} + (aw_lp + 1)'(r_row);
  assign w_in_range = (w_sum <= (aw_lp + 1)'(height_p - 1));
  assign w_row      = r_piece[piece_cols_lp*r_row +: piece_cols_lp];

  piece_row_shifter #(.width_p(width_p)) u_shifter (
    .row_i  (w_row),
    .x_i    (r_x),
    .mask_o (w_mask),
    .clip_o (w_shift_clip)
  );

  // A row landing below the matrix is dropped and counts as clipped.
  assign w_clip_now = w_shift_clip | (~w_in_range & (|w_row));
  // Reset gates the write so an aborted merge stops immediately.
  assign w_write    = w_merge & w_in_range & (|w_mask) & ~reset_i;

  assign ready_o         = (r_state == eIDLE);
  assign done_o          = (r_state == eDone);
  assign mm_read_addr_o  = w_merge ? w_sum[aw_lp-1:0] : '0;
  assign mm_write_addr_o = mm_read_addr_o;
  assign mm_write_data_o = mm_read_data_i | w_mask;
  assign mm_write_v_o    = w_write;
  assign clip_o          = r_clip;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIDLE;
      r_row   <= '0;
      r_piece <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_clip  <= 1'b0;
    end else begin
      case (r_state)
        eIDLE: begin
          if (v_i) begin
            r_piece <= piece_i;
            r_x     <= x_i;
            r_y     <= y_i;
            r_row   <= '0;
            r_clip  <= 1'b0;
            r_state <= eMerge;
          end
        end
        eMerge: begin
          if (w_clip_now) r_clip <= 1'b1;
          r_row <= r_row + 2'd1;
          if (r_row == 2'(piece_rows_lp - 1)) r_state <= eDone;
        end
        default: r_state <= eIDLE;
      endcase
    end
  end

`ifdef EXECUTOR_MERGE_COLLISION_EN
  logic r_collision;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_collision <= 1'b0;
    end else if (ready_o && v_i) begin
      r_collision <= 1'b0;
    end else if (w_write && (|(mm_read_data_i & w_mask))) begin
      r_collision <= 1'b1;
    end
  end

  assign collision_o = r_collision;
`else
  assign collision_o = 1'b0;
`endif

  always_comb begin
    debug_o = '0;
    if (debug_p != 0) begin
      debug_o.state     = r_state;
      debug_o.row       = r_row;
      debug_o.collision = collision_o;
      debug_o.clip      = r_clip;
    end
  end

endmodule

// File: tb/tb_executor_merge.sv
// Scoreboard bench for executor_merge: directed pieces against a model matrix.
module tb_executor_merge;
  import tetris_pkg::*;

`ifdef EXECUTOR_MERGE_COLLISION_EN
  localparam bit coll_en = 1'b1;
`else
  localparam bit coll_en = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic         ready_o;
  logic [15:0]  piece_i;
  logic [3:0]   x_i;
  logic [4:0]   y_i;
  logic [4:0]   mm_read_addr_o;
  logic [15:0]  mm_read_data_i;
  logic [4:0]   mm_write_addr_o;
  logic [15:0]  mm_write_data_o;
  logic         mm_write_v_o;
  logic         done_o;
  logic         collision_o;
  logic         clip_o;
  merge_debug_s debug_o;

  executor_merge #(.width_p(16), .height_p(32), .debug_p(1)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .v_i             (v_i),
    .ready_o         (ready_o),
    .piece_i         (piece_i),
    .x_i             (x_i),
    .y_i             (y_i),
    .mm_read_addr_o  (mm_read_addr_o),
    .mm_read_data_i  (mm_read_data_i),
    .mm_write_addr_o (mm_write_addr_o),
    .mm_write_data_o (mm_write_data_o),
    .mm_write_v_o    (mm_write_v_o),
    .done_o          (done_o),
    .collision_o     (collision_o),
    .clip_o          (clip_o),
    .debug_o         (debug_o)
  );

  // clock / reset / model matrix
  always #5 clk = ~clk;

  logic [15:0] mem [32];
  assign mm_read_data_i = mem[mm_read_addr_o];
  always @(posedge clk) if (mm_write_v_o) mem[mm_write_addr_o] <= mm_write_data_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] wr_q[$];    // {addr, data}
  logic [17:0] done_q[$];  // {done cycle, collision, clip}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mm_write_v_o) begin
      if (wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mm_write_addr_o, mm_write_data_o);
      end else begin
        logic [20:0] e;
        e = wr_q.pop_front();
        check("write", 32'({mm_write_addr_o, mm_write_data_o}), 32'(e));
        check("rw_addr_equal", 32'(mm_read_addr_o), 32'(mm_write_addr_o));
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        logic [17:0] d;
        d = done_q.pop_front();
        check("done_cyc_coll_clip", 32'({cyc[15:0], collision_o, clip_o}), 32'(d));
      end
    end
  end

  // driver tasks
  task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !ready_o; i++) @(negedge clk);
    check("ready_wait", 32'(ready_o), 32'd1);
  endtask

  task automatic go(input logic [15:0] p, input logic [3:0] x, input logic [4:0] y,
                    input bit push_done, input bit ec, input bit ecl, output int t);
    wait_ready();
    piece_i = p;
    x_i     = x;
    y_i     = y;
    v_i     = 1'b1;
    t       = cyc;
    if (push_done) done_q.push_back({16'(t + 5), ec, ecl});
    @(negedge clk);
    v_i = 1'b0;
    check("busy_after_accept", 32'(ready_o), 32'd0);
    check("state_merge", 32'(debug_o.state), 32'(eMerge));
    check("row_start", 32'(debug_o.row), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (wr_q.size() != 0 || done_q.size() != 0); i++) @(negedge clk);
    check("drain_pending", 32'(wr_q.size() + done_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
    reset_i = 1'b1;
    v_i     = 1'b0;
    piece_i = '0;
    x_i     = '0;
    y_i     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_wv", 32'(mm_write_v_o), 32'd0);
    check("rst_raddr", 32'(mm_read_addr_o), 32'd0);
    check("rst_flags", 32'({collision_o, clip_o}), 32'd0);
    check("rst_state", 32'(debug_o.state), 32'(eIDLE));
    reset_i = 1'b0;
    @(negedge clk);

    // two-row square at x=3, y=10
    push_wr(5'd10, 16'h0018);
    push_wr(5'd11, 16'h0018);
    go(16'h0033, 4'd3, 5'd10, 1'b1, 1'b0, 1'b0, t);
    drain();
    check("flags_hold_after_done", 32'({collision_o, clip_o}), 32'd0);

    // right-edge clip
    push_wr(5'd0, 16'hC000);
    go(16'h000F, 4'd14, 5'd0, 1'b1, 1'b0, 1'b1, t);
    drain();
    check("clip_held", 32'(clip_o), 32'd1);

    // bottom clip: only row 3 populated, lands on row 32
    go(16'hF000, 4'd0, 5'd29, 1'b1, 1'b0, 1'b1, t);
    drain();

    // overlap with existing cell
    mem[5] <= 16'h0010;
    @(negedge clk);
    push_wr(5'd5, 16'h0010);
    go(16'h0001, 4'd4, 5'd5, 1'b1, coll_en, 1'b0, t);
    drain();
    check("coll_held", 32'(collision_o), 32'(coll_en));

    // diagonal onto a partly filled region
    mem[21] <= 16'h0100;
    @(negedge clk);
    push_wr(5'd20, 16'h0001);
    push_wr(5'd21, 16'h0102);
    push_wr(5'd22, 16'h0004);
    push_wr(5'd23, 16'h0008);
    go(16'h8421, 4'd0, 5'd20, 1'b1, 1'b0, 1'b0, t);
    drain();

    // last column, last row: row 1 both shifts out and falls off the bottom
    push_wr(5'd31, 16'h8000);
    go(16'h0021, 4'd15, 5'd31, 1'b1, 1'b0, 1'b1, t);
    drain();

    // reset two cycles after accept aborts the merge
    push_wr(5'd24, 16'h0001);
    go(16'h1111, 4'd0, 5'd24, 1'b0, 1'b0, 1'b0, t);
    @(negedge clk);
    check("abort_cycle", 32'(cyc), 32'(t + 2));
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_state", 32'(debug_o.state), 32'(eIDLE));
    check("abort_clip", 32'(clip_o), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_row25", 32'(mem[25]), 32'd0);
    check("abort_wr_left", 32'(wr_q.size()), 32'd0);

    // v_i held high: accepts at T and T+6 only
    wait_ready();
    piece_i = 16'h0001;
    x_i     = 4'd0;
    y_i     = 5'd8;
    v_i     = 1'b1;
    t       = cyc;
    push_wr(5'd8, 16'h0001);
    push_wr(5'd8, 16'h0001);
    done_q.push_back({16'(t + 5), 1'b0, 1'b0});
    done_q.push_back({16'(t + 11), coll_en, 1'b0});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("hold_ready", 32'(ready_o), 32'(k == 6));
    end
    @(negedge clk);
    v_i = 1'b0;
    drain();

    check("mem_row10", 32'(mem[10]), 32'h0018);
    check("mem_row12", 32'(mem[12]), 32'h0000);
    check("mem_row13", 32'(mem[13]), 32'h0000);
    check("mem_row0", 32'(mem[0]), 32'hC000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
